// File: rtl/id_ex_if.sv
// Bundle of decode-side, forwarding and ALU-side signals for the ID/EX stage.
// The master drives the decoded instruction, pipeline control and writebacks; the slave returns ALU operands.
interface id_ex_if #(
    parameter int WIDTH = 16,
    parameter int RADDR = 2
);
    // in_valid qualifies the decode slot; there is no ready. stall holds the stage and flush empties it.
    logic             in_valid;
    logic [RADDR-1:0] in_rs_addr;
    logic [RADDR-1:0] in_rt_addr;
    logic [RADDR-1:0] in_rd_addr;
    logic [WIDTH-1:0] in_rs_data;
    logic [WIDTH-1:0] in_rt_data;
    logic [WIDTH-1:0] in_imm;
    logic             in_use_imm;
    logic [2:0]       in_func;
    logic             in_reg_write;
    logic             stall;
    logic             flush;
    logic             exmem_reg_write;
    logic [RADDR-1:0] exmem_rd;
    logic [WIDTH-1:0] exmem_value;
    logic             memwb_reg_write;
    logic [RADDR-1:0] memwb_rd;
    logic [WIDTH-1:0] memwb_value;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_func;
    logic [WIDTH-1:0] rt_fwd;
    logic             out_valid;
    logic             out_reg_write;
    logic [RADDR-1:0] out_rd_addr;

    modport master (
        output in_valid, in_rs_addr, in_rt_addr, in_rd_addr, in_rs_data, in_rt_data,
               in_imm, in_use_imm, in_func, in_reg_write, stall, flush,
               exmem_reg_write, exmem_rd, exmem_value,
               memwb_reg_write, memwb_rd, memwb_value,
        input  alu_a, alu_b, alu_func, rt_fwd, out_valid, out_reg_write, out_rd_addr
    );

    modport slave (
        input  in_valid, in_rs_addr, in_rt_addr, in_rd_addr, in_rs_data, in_rt_data,
               in_imm, in_use_imm, in_func, in_reg_write, stall, flush,
               exmem_reg_write, exmem_rd, exmem_value,
               memwb_reg_write, memwb_rd, memwb_value,
        output alu_a, alu_b, alu_func, rt_fwd, out_valid, out_reg_write, out_rd_addr
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with capture-time write-back bypass and EX/MEM, MEM/WB operand forwarding.
// Holds under stall, becomes a bubble on flush; drives the ALU operands and function code.
module id_ex_stage #(
    parameter int WIDTH = 16,
    parameter int RADDR = 2
) (
    input  logic     clk,
    input  logic     reset_n,
    id_ex_if.slave   bus
);
    localparam logic [2:0] FUNC_ADD = 3'b000;

    logic             valid_q,     valid_d;
    logic [RADDR-1:0] rs_addr_q,   rs_addr_d;
    logic [RADDR-1:0] rt_addr_q,   rt_addr_d;
    logic [RADDR-1:0] rd_addr_q,   rd_addr_d;
    logic [WIDTH-1:0] rs_data_q,   rs_data_d;
    logic [WIDTH-1:0] rt_data_q,   rt_data_d;
    logic [WIDTH-1:0] imm_q,       imm_d;
    logic             use_imm_q,   use_imm_d;
    logic [2:0]       func_q,      func_d;
    logic             reg_write_q, reg_write_d;

    logic [WIDTH-1:0] rs_fwd;
    logic [WIDTH-1:0] rt_fwd_w;

    always_comb begin
        valid_d     = valid_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        rd_addr_d   = rd_addr_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        func_d      = func_q;
        reg_write_d = reg_write_q;

        if (bus.flush) begin
            valid_d     = 1'b0;
            rs_addr_d   = '0;
            rt_addr_d   = '0;
            rd_addr_d   = '0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            imm_d       = '0;
            use_imm_d   = 1'b0;
            func_d      = FUNC_ADD;
            reg_write_d = 1'b0;
        end else if (bus.stall) begin
            // A write-back retiring during the stall must land in the held operands.
            if (bus.memwb_reg_write && (bus.memwb_rd == rs_addr_q))
                rs_data_d = bus.memwb_value;
            if (bus.memwb_reg_write && (bus.memwb_rd == rt_addr_q))
                rt_data_d = bus.memwb_value;
        end else begin
            valid_d     = bus.in_valid;
            rs_addr_d   = bus.in_rs_addr;
            rt_addr_d   = bus.in_rt_addr;
            rd_addr_d   = bus.in_rd_addr;
            imm_d       = bus.in_imm;
            use_imm_d   = bus.in_use_imm;
            func_d      = bus.in_func;
            reg_write_d = bus.in_reg_write;
            // The register file writes on this same edge, so its read data is stale for a matching address.
            rs_data_d = (bus.memwb_reg_write && (bus.memwb_rd == bus.in_rs_addr))
                        ? bus.memwb_value : bus.in_rs_data;
            rt_data_d = (bus.memwb_reg_write && (bus.memwb_rd == bus.in_rt_addr))
                        ? bus.memwb_value : bus.in_rt_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= 1'b0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_addr_q   <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            func_q      <= FUNC_ADD;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            rd_addr_q   <= rd_addr_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            func_q      <= func_d;
            reg_write_q <= reg_write_d;
        end
    end

    // EX/MEM is the newer result, so it wins over MEM/WB.
    always_comb begin
        rs_fwd = rs_data_q;
        if (bus.exmem_reg_write && (bus.exmem_rd == rs_addr_q))
            rs_fwd = bus.exmem_value;
        else if (bus.memwb_reg_write && (bus.memwb_rd == rs_addr_q))
            rs_fwd = bus.memwb_value;

        rt_fwd_w = rt_data_q;
        if (bus.exmem_reg_write && (bus.exmem_rd == rt_addr_q))
            rt_fwd_w = bus.exmem_value;
        else if (bus.memwb_reg_write && (bus.memwb_rd == rt_addr_q))
            rt_fwd_w = bus.memwb_value;
    end

    assign bus.alu_a         = rs_fwd;
    assign bus.alu_b         = use_imm_q ? imm_q : rt_fwd_w;
    assign bus.rt_fwd        = rt_fwd_w;
    assign bus.alu_func      = func_q;
    assign bus.out_valid     = valid_q;
    assign bus.out_reg_write = reg_write_q;
    assign bus.out_rd_addr   = rd_addr_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for load/forwarding plus hand sequences
// for reset, capture bypass, stall/flush and stall refresh.
module tb_id_ex_stage;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  id_ex_if #(.WIDTH(16), .RADDR(2)) bus ();

  id_ex_stage #(.WIDTH(16), .RADDR(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rs, rt, rd;
    logic [15:0] rsd, rtd, imm;
    logic        use_imm;
    logic [2:0]  func;
    logic        reg_write;
    logic        ex_we;
    logic [1:0]  ex_rd;
    logic [15:0] ex_val;
    logic        wb_we;
    logic [1:0]  wb_rd;
    logic [15:0] wb_val;
    logic [15:0] exp_a, exp_b, exp_rt;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fwd_off();
    bus.exmem_reg_write = 1'b0;
    bus.exmem_rd        = 2'd0;
    bus.exmem_value     = 16'h0;
    bus.memwb_reg_write = 1'b0;
    bus.memwb_rd        = 2'd0;
    bus.memwb_value     = 16'h0;
  endtask

  task automatic drive_in(input logic [1:0] rs, input logic [1:0] rt, input logic [1:0] rd,
                          input logic [15:0] rsd, input logic [15:0] rtd, input logic [15:0] imm,
                          input logic use_imm, input logic [2:0] func, input logic reg_write);
    bus.in_valid     = 1'b1;
    bus.in_rs_addr   = rs;
    bus.in_rt_addr   = rt;
    bus.in_rd_addr   = rd;
    bus.in_rs_data   = rsd;
    bus.in_rt_data   = rtd;
    bus.in_imm       = imm;
    bus.in_use_imm   = use_imm;
    bus.in_func      = func;
    bus.in_reg_write = reg_write;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //            rs    rt    rd    rsd       rtd       imm       ui    func  rw    exwe  exrd  exval     wbwe  wbrd  wbval     exp_a     exp_b     exp_rt
    vecs[0] = '{2'd1, 2'd2, 2'd3, 16'h1111, 16'h2222, 16'h0000, 1'b0, 3'd1, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 16'h1111, 16'h2222, 16'h2222};
    vecs[1] = '{2'd0, 2'd3, 2'd1, 16'h0ABC, 16'h0007, 16'hFFF0, 1'b1, 3'd2, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 16'h0ABC, 16'hFFF0, 16'h0007};
    vecs[2] = '{2'd2, 2'd1, 2'd0, 16'h0001, 16'h0002, 16'h0000, 1'b0, 3'd3, 1'b1, 1'b1, 2'd2, 16'hAAAA, 1'b1, 2'd2, 16'h5555, 16'hAAAA, 16'h0002, 16'h0002};
    vecs[3] = '{2'd2, 2'd1, 2'd0, 16'h0001, 16'h0002, 16'h0000, 1'b0, 3'd4, 1'b0, 1'b0, 2'd2, 16'hAAAA, 1'b1, 2'd2, 16'h5555, 16'h5555, 16'h0002, 16'h0002};
    vecs[4] = '{2'd2, 2'd1, 2'd0, 16'h0001, 16'h0002, 16'h0000, 1'b0, 3'd5, 1'b1, 1'b1, 2'd3, 16'hAAAA, 1'b1, 2'd2, 16'h5555, 16'h5555, 16'h0002, 16'h0002};
    vecs[5] = '{2'd0, 2'd3, 2'd2, 16'h0F0F, 16'h3333, 16'h0010, 1'b1, 3'd6, 1'b1, 1'b1, 2'd3, 16'hCCCC, 1'b0, 2'd0, 16'h0000, 16'h0F0F, 16'h0010, 16'hCCCC};
    vecs[6] = '{2'd3, 2'd1, 2'd1, 16'h4444, 16'h1212, 16'h9999, 1'b0, 3'd7, 1'b0, 1'b0, 2'd1, 16'hDDDD, 1'b1, 2'd1, 16'h7777, 16'h4444, 16'h7777, 16'h7777};

    // Reset with a live instruction at the input
    fwd_off();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive_in(2'd0, 2'd0, 2'd1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'b101, 1'b1);
    reset_n = 1'b0;
    tick();
    tick();
    check("reset_valid", {15'd0, bus.out_valid}, 16'h0);
    check("reset_reg_write", {15'd0, bus.out_reg_write}, 16'h0);
    check("reset_func", {13'd0, bus.alu_func}, 16'h0);
    check("reset_alu_a", bus.alu_a, 16'h0);
    check("reset_alu_b", bus.alu_b, 16'h0);
    bus.in_rs_data = 16'h1234;
    bus.in_rt_data = 16'h0003;
    #2 reset_n = 1'b1;
    tick();
    check("post_reset_alu_a", bus.alu_a, 16'h1234);
    check("post_reset_alu_b", bus.alu_b, 16'h0003);
    check("post_reset_valid", {15'd0, bus.out_valid}, 16'h1);
    check("post_reset_func", {13'd0, bus.alu_func}, 16'h5);

    // Table: load with no forwards active, then apply the vector's forwards combinationally
    for (int i = 0; i < 7; i++) begin
      fwd_off();
      drive_in(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].rsd, vecs[i].rtd, vecs[i].imm,
               vecs[i].use_imm, vecs[i].func, vecs[i].reg_write);
      tick();
      bus.exmem_reg_write = vecs[i].ex_we;
      bus.exmem_rd        = vecs[i].ex_rd;
      bus.exmem_value     = vecs[i].ex_val;
      bus.memwb_reg_write = vecs[i].wb_we;
      bus.memwb_rd        = vecs[i].wb_rd;
      bus.memwb_value     = vecs[i].wb_val;
      #1;
      check($sformatf("vec%0d_alu_a", i), bus.alu_a, vecs[i].exp_a);
      check($sformatf("vec%0d_alu_b", i), bus.alu_b, vecs[i].exp_b);
      check($sformatf("vec%0d_rt_fwd", i), bus.rt_fwd, vecs[i].exp_rt);
      check($sformatf("vec%0d_func", i), {13'd0, bus.alu_func}, {13'd0, vecs[i].func});
      check($sformatf("vec%0d_rd", i), {14'd0, bus.out_rd_addr}, {14'd0, vecs[i].rd});
      check($sformatf("vec%0d_reg_write", i), {15'd0, bus.out_reg_write}, {15'd0, vecs[i].reg_write});
      check($sformatf("vec%0d_valid", i), {15'd0, bus.out_valid}, 16'h1);
    end

    // Capture bypass: write-back on the load edge replaces stale register-file data
    fwd_off();
    drive_in(2'd1, 2'd2, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b1);
    bus.memwb_reg_write = 1'b1;
    bus.memwb_rd        = 2'd1;
    bus.memwb_value     = 16'hBEEF;
    tick();
    fwd_off();
    bus.stall = 1'b1;
    #1;
    check("bypass_alu_a", bus.alu_a, 16'hBEEF);
    tick();
    check("bypass_alu_a_held", bus.alu_a, 16'hBEEF);
    bus.stall = 1'b0;

    // Stall holds X for three cycles while the inputs change, then stall+flush empties the stage
    fwd_off();
    drive_in(2'd1, 2'd2, 2'd3, 16'h1357, 16'h2468, 16'h0000, 1'b0, 3'd3, 1'b1);
    tick();
    bus.stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive_in(2'(c), 2'(c + 1), 2'd0, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
               16'hFFFF, 1'b1, 3'd6, 1'b0);
      tick();
      check($sformatf("stall%0d_alu_a", c), bus.alu_a, 16'h1357);
      check($sformatf("stall%0d_alu_b", c), bus.alu_b, 16'h2468);
      check($sformatf("stall%0d_func", c), {13'd0, bus.alu_func}, 16'h3);
      check($sformatf("stall%0d_rd", c), {14'd0, bus.out_rd_addr}, 16'h3);
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_valid", {15'd0, bus.out_valid}, 16'h0);
    check("flush_reg_write", {15'd0, bus.out_reg_write}, 16'h0);
    check("flush_func", {13'd0, bus.alu_func}, 16'h0);
    check("flush_alu_a", bus.alu_a, 16'h0);
    check("flush_alu_b", bus.alu_b, 16'h0);
    bus.stall = 1'b0;

    // Stall refresh: write-back retiring during a stall updates held rt data
    fwd_off();
    drive_in(2'd1, 2'd0, 2'd2, 16'h0005, 16'h0001, 16'h0000, 1'b0, 3'd1, 1'b1);
    tick();
    check("refresh_before", bus.alu_b, 16'h0001);
    bus.stall           = 1'b1;
    bus.memwb_reg_write = 1'b1;
    bus.memwb_rd        = 2'd0;
    bus.memwb_value     = 16'h0042;
    tick();
    fwd_off();
    #1;
    check("refresh_alu_b", bus.alu_b, 16'h0042);
    check("refresh_rt_fwd", bus.rt_fwd, 16'h0042);
    check("refresh_alu_a", bus.alu_a, 16'h0005);

    // Asynchronous reset while stalled
    #1 reset_n = 1'b0;
    #1;
    check("reset_stall_valid", {15'd0, bus.out_valid}, 16'h0);
    check("reset_stall_alu_b", bus.alu_b, 16'h0);
    tick();
    check("reset_stall_func", {13'd0, bus.alu_func}, 16'h0);
    bus.stall = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
